// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/data requester and memory port signals of the shared memory arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          if_stall;
  logic          d_req;
  logic [3:0]    d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          d_stall;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serializes IF fetches and data accesses onto one memory port with starvation-bounded data priority
module mem_port_arbiter #(
  parameter int MAX_STARVE = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t        state, state_nxt;
  logic [3:0]    starve, starve_nxt;
  logic          own_d, own_d_nxt;
  logic          en_q, en_nxt;
  logic [3:0]    we_q, we_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic [DW-1:0] if_rd_q, if_rd_nxt;
  logic [DW-1:0] d_rd_q, d_rd_nxt;
  logic          if_v_q, if_v_nxt;
  logic          d_v_q, d_v_nxt;
  logic          grant_d;
  // data has priority until IF has been passed over MAX_STARVE times in a row
  assign grant_d = bus.d_req & (~bus.if_req | (starve != 4'(MAX_STARVE)));
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve;
    own_d_nxt  = own_d;
    en_nxt     = 1'b0;
    we_nxt     = we_q;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    if_rd_nxt  = if_rd_q;
    d_rd_nxt   = d_rd_q;
    if_v_nxt   = 1'b0;
    d_v_nxt    = 1'b0;
    case (state)
      IDLE: if (bus.if_req | bus.d_req) begin
        state_nxt  = ISSUE;
        own_d_nxt  = grant_d;
        en_nxt     = 1'b1;
        we_nxt     = grant_d ? bus.d_we : 4'b0;
        addr_nxt   = grant_d ? bus.d_addr : bus.if_addr;
        wdata_nxt  = grant_d ? bus.d_wdata : '0;
        starve_nxt = !grant_d ? 4'd0 :
                     (bus.if_req && starve != 4'(MAX_STARVE)) ? starve + 4'd1 : starve;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: if (bus.mem_ack) begin
        state_nxt = RESP;
        if_rd_nxt = own_d ? if_rd_q : bus.mem_rdata;
        d_rd_nxt  = own_d ? bus.mem_rdata : d_rd_q;
        if_v_nxt  = ~own_d;
        d_v_nxt   = own_d;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      starve  <= 4'd0;
      own_d   <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 4'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      if_rd_q <= '0;
      d_rd_q  <= '0;
      if_v_q  <= 1'b0;
      d_v_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      starve  <= starve_nxt;
      own_d   <= own_d_nxt;
      en_q    <= en_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      if_rd_q <= if_rd_nxt;
      d_rd_q  <= d_rd_nxt;
      if_v_q  <= if_v_nxt;
      d_v_q   <= d_v_nxt;
    end
  end
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rd_q;
  assign bus.d_rdata   = d_rd_q;
  assign bus.if_valid  = if_v_q;
  assign bus.d_valid   = d_v_q;
  assign bus.if_stall  = bus.if_req & ~if_v_q;
  assign bus.d_stall   = bus.d_req & ~d_v_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, reset/back-to-back/starvation sequences and a random run against a timeline model
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MS = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();
  mem_port_arbiter #(.MAX_STARVE(MS), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  logic [31:0] last_if, last_d;
  int dut_en[$];
  byte dut_ord[$];
  typedef struct {
    bit use_d; logic [3:0] we; logic [31:0] addr; logic [31:0] wdata; int lat; logic [31:0] mdata;
    logic [3:0] exp_we; logic [31:0] exp_wdata; int vcyc; logic [31:0] exp_rd;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mem_en"}, bus.mem_en, 0);
    chk({tag, " mem_we"}, bus.mem_we, 0);
    chk({tag, " mem_addr"}, bus.mem_addr, 0);
    chk({tag, " mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, " if_valid"}, bus.if_valid, 0);
    chk({tag, " d_valid"}, bus.d_valid, 0);
    chk({tag, " if_rdata"}, bus.if_rdata, 0);
    chk({tag, " d_rdata"}, bus.d_rdata, 0);
    chk({tag, " if_stall"}, bus.if_stall, 0);
    chk({tag, " d_stall"}, bus.d_stall, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    chk_zero("reset");
    rst = 0;
    last_if = 0;
    last_d = 0;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    bit ack;
    for (int t = 0; t <= v.vcyc; t++) begin
      @(negedge clk);
      if (t > 0) begin
        chk($sformatf("v%0d mem_en t%0d", k, t), bus.mem_en, t == 1);
        if (t == 1) begin
          chk($sformatf("v%0d mem_addr", k), bus.mem_addr, v.addr);
          chk($sformatf("v%0d mem_we", k), bus.mem_we, v.exp_we);
          chk($sformatf("v%0d mem_wdata", k), bus.mem_wdata, v.exp_wdata);
        end
        chk($sformatf("v%0d if_valid t%0d", k, t), bus.if_valid, t == v.vcyc && !v.use_d);
        chk($sformatf("v%0d d_valid t%0d", k, t), bus.d_valid, t == v.vcyc && v.use_d);
        if (t == v.vcyc) begin
          if (v.use_d) last_d = v.exp_rd;
          else last_if = v.exp_rd;
        end
        chk($sformatf("v%0d if_rdata t%0d", k, t), bus.if_rdata, last_if);
        chk($sformatf("v%0d d_rdata t%0d", k, t), bus.d_rdata, last_d);
      end
      bus.if_req = !v.use_d && t < v.vcyc;
      bus.d_req = v.use_d && t < v.vcyc;
      bus.if_addr = v.addr;
      bus.d_addr = v.addr;
      bus.d_we = v.we;
      bus.d_wdata = v.wdata;
      ack = (t == 1 + v.lat);
      bus.mem_ack = ack;
      bus.mem_rdata = ack ? v.mdata : $urandom;
      #1;
      chk($sformatf("v%0d if_stall t%0d", k, t), bus.if_stall, !v.use_d && t < v.vcyc);
      chk($sformatf("v%0d d_stall t%0d", k, t), bus.d_stall, v.use_d && t < v.vcyc);
    end
  endtask

  // Timeline model: an access decided at cycle c issues at c+1, is acked at c+1+lat,
  // responds at c+2+lat and the port can decide again at c+3+lat.
  task automatic run_model(input bit rs, input int ncyc, input int p_if, input int p_d,
                           input int lmin, input int lmax);
    int next_free, en_cyc, ack_cyc, v_cyc, starve, lat;
    bit own_d, gd, if_p, d_p, ev_if, ev_d;
    logic [3:0] e_we;
    logic [31:0] e_addr, e_wdata, e_rd, pc;
    if (rs) do_reset();
    next_free = 0; en_cyc = -1; ack_cyc = -1; v_cyc = -1; starve = 0;
    own_d = 0; if_p = 0; d_p = 0; pc = 32'h1000;
    e_we = 0; e_addr = 0; e_wdata = 0; e_rd = 0;
    dut_en.delete();
    dut_ord.delete();
    for (int c = 0; c < ncyc + 40; c++) begin
      @(negedge clk);
      chk($sformatf("m mem_en c%0d", c), bus.mem_en, c == en_cyc);
      if (c == en_cyc) begin
        chk($sformatf("m mem_addr c%0d", c), bus.mem_addr, e_addr);
        chk($sformatf("m mem_we c%0d", c), bus.mem_we, e_we);
        chk($sformatf("m mem_wdata c%0d", c), bus.mem_wdata, e_wdata);
      end
      ev_if = c == v_cyc && !own_d;
      ev_d = c == v_cyc && own_d;
      chk($sformatf("m if_valid c%0d", c), bus.if_valid, ev_if);
      chk($sformatf("m d_valid c%0d", c), bus.d_valid, ev_d);
      if (ev_if) last_if = e_rd;
      if (ev_d) last_d = e_rd;
      chk($sformatf("m if_rdata c%0d", c), bus.if_rdata, last_if);
      chk($sformatf("m d_rdata c%0d", c), bus.d_rdata, last_d);
      if (bus.mem_en) dut_en.push_back(c);
      if (bus.if_valid) dut_ord.push_back("I");
      if (bus.d_valid) dut_ord.push_back("D");
      if (ev_if) if_p = 0;
      if (ev_d) d_p = 0;
      if (!if_p && c < ncyc && $urandom_range(99) < p_if) begin
        if_p = 1;
        bus.if_addr = pc;
        pc += 4;
      end
      if (!d_p && c < ncyc && $urandom_range(99) < p_d) begin
        d_p = 1;
        bus.d_addr = $urandom & ~32'h3;
        bus.d_we = $urandom_range(1) ? 4'($urandom) : 4'b0;
        bus.d_wdata = $urandom;
      end
      bus.if_req = if_p;
      bus.d_req = d_p;
      bus.mem_ack = c == ack_cyc;
      bus.mem_rdata = c == ack_cyc ? e_rd : $urandom;
      if (c >= next_free && (if_p || d_p)) begin
        gd = d_p && (!if_p || starve != MS);
        starve = !gd ? 0 : (if_p && starve < MS) ? starve + 1 : starve;
        own_d = gd;
        e_addr = gd ? bus.d_addr : bus.if_addr;
        e_we = gd ? bus.d_we : 4'b0;
        e_wdata = gd ? bus.d_wdata : 32'h0;
        e_rd = $urandom;
        lat = lmin + $urandom_range(lmax - lmin);
        en_cyc = c + 1;
        ack_cyc = c + 1 + lat;
        v_cyc = c + 2 + lat;
        next_free = c + 3 + lat;
      end
      #1;
      chk($sformatf("m if_stall c%0d", c), bus.if_stall, if_p && !ev_if);
      chk($sformatf("m d_stall c%0d", c), bus.d_stall, d_p && !ev_d);
    end
    chk("m drain", {if_p, d_p}, 0);
  endtask

  initial begin
    string ord = "DDIDDI";
    idle_inputs();
    vt[0] = '{0, 4'h0, 32'h1000, 32'h0,        1, 32'h13,   4'h0, 32'h0,        3, 32'h13};
    vt[1] = '{1, 4'hf, 32'h2004, 32'hDEADBEEF, 1, 32'h55,   4'hf, 32'hDEADBEEF, 3, 32'h55};
    vt[2] = '{0, 4'h0, 32'h1008, 32'hCAFE,     2, 32'h93,   4'h0, 32'h0,        4, 32'h93};
    vt[3] = '{1, 4'h0, 32'h3000, 32'h0,        5, 32'hABCD, 4'h0, 32'h0,        7, 32'hABCD};
    vt[4] = '{1, 4'h3, 32'h3010, 32'h1234,     3, 32'h0,    4'h3, 32'h1234,     5, 32'h0};
    do_reset();
    for (int k = 0; k < 5; k++) run_vec(vt[k], k);
    // reset while the access waits for its ack; the late ack must be ignored
    do_reset();
    @(negedge clk);
    bus.if_req = 1; bus.if_addr = 32'h1000;
    @(negedge clk);
    chk("rw mem_en", bus.mem_en, 1);
    @(negedge clk);
    chk("rw wait mem_en", bus.mem_en, 0);
    rst = 1; bus.if_req = 0;
    @(negedge clk);
    chk_zero("rw rst");
    rst = 0;
    @(negedge clk);
    bus.mem_ack = 1; bus.mem_rdata = 32'h77;
    @(negedge clk);
    bus.mem_ack = 0;
    chk_zero("rw stray1");
    @(negedge clk);
    chk_zero("rw stray2");
    last_if = 0; last_d = 0;
    run_model(0, 20, 100, 0, 1, 1);
    chk("b2b spacing", dut_en.size() > 1 ? dut_en[1] - dut_en[0] : 0, 4);
    run_model(1, 40, 100, 100, 1, 1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("order %0d", i), dut_ord.size() > i ? dut_ord[i] : 8'd0, ord[i]);
    run_model(1, 3000, 55, 55, 1, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
